// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared FSM state, FIFO entry type and defaults for data_store_buffer.
package store_buffer_pkg;
  localparam int DEFAULT_DEPTH = 4;
  localparam int MAX_ADDR_W = 64;
  typedef enum logic [1:0] {IDLE, WRITE, READ} sb_state_t;
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [31:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_fifo.sv
// store_fifo: circular buffer of pending stores; entries and read pointer are exposed for forwarding.
module store_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic pop,
  input  sb_entry_t din,
  output sb_entry_t head,
  output logic full,
  output logic empty,
  output logic [PW:0] count,
  output logic [PW-1:0] rptr,
  output sb_entry_t entries [DEPTH]
);
  logic [PW-1:0] wptr;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = entries[rptr];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
  // Payload needs no reset: only slots inside [rptr, rptr+count) are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) entries[wptr] <= din;
  end
endmodule

// File: rtl/data_store_buffer.sv
// data_store_buffer: in-order store buffer between core and memory with a blocking load path.
// Define STORE_FWD_EN to let loads hit buffered stores and return the youngest match without a memory read.
module data_store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ADDR_W = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0] write_data_i,
  input  logic mem_write_i,
  input  logic mem_read_i,
  output logic [31:0] read_data_o,
  output logic stall_o,
  output logic mem_req_o,
  output logic mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic mem_ack_i,
  input  logic [31:0] mem_rdata_i
);
  sb_state_t state, state_n;
  sb_entry_t din, head;
  sb_entry_t entries [DEPTH];
  logic full, empty, push, pop, load, rd_ack, fwd_hit;
  logic [PW:0] count;
  logic [PW-1:0] rptr;
  logic [31:0] fwd_data;
  logic [ADDR_W-1:0] word_addr;
  assign word_addr = {data_addr_i[ADDR_W-1:2], 2'b00};
  assign din = {MAX_ADDR_W'(word_addr), write_data_i};
  assign push = mem_write_i && !full;
  assign pop = state == WRITE && mem_ack_i;
  assign load = mem_read_i && !mem_write_i;
  assign rd_ack = state == READ && mem_ack_i;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count),
    .rptr(rptr),
    .entries(entries)
  );

`ifdef STORE_FWD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (load && (PW+1)'(i) < count &&
          entries[rptr + PW'(i)].addr[ADDR_W-1:2] == data_addr_i[ADDR_W-1:2]) begin
        fwd_hit = 1'b1;
        fwd_data = entries[rptr + PW'(i)].data;
      end
    end
  end
`else
  assign fwd_hit = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end

  // Leaving IDLE on a push keeps first-store latency at one cycle.
  always_comb begin
    state_n = state == IDLE ? ((!empty || push) ? WRITE : (load && !fwd_hit) ? READ : IDLE)
            : state == WRITE ? ((pop && count == (PW+1)'(1) && !push) ? IDLE : WRITE)
            : rd_ack ? IDLE : READ;
    stall_o = mem_write_i ? full : load && !fwd_hit && !rd_ack;
    mem_req_o = state != IDLE;
    mem_we_o = state == WRITE;
    mem_addr_o = state == WRITE ? head.addr[ADDR_W-1:0] : state == READ ? word_addr : '0;
    mem_wdata_o = state == WRITE ? head.data : '0;
    read_data_o = fwd_hit ? fwd_data : rd_ack ? mem_rdata_i : '0;
  end
endmodule

// File: tb/tb_data_store_buffer.sv
// tb_data_store_buffer: directed stimulus with a scoreboard queue checked by a memory-side monitor.
module tb_data_store_buffer;
  logic clk = 1'b0;
  logic rst_i, mem_write_i, mem_read_i, mem_ack_i, stall_o, mem_req_o, mem_we_o;
  logic [31:0] data_addr_i, write_data_i, read_data_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  int checks = 0;
  int errors = 0;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  txn_t exp_q[$];

  always #5 clk = ~clk;

  data_store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_addr_i(data_addr_i), .write_data_i(write_data_i),
    .mem_write_i(mem_write_i), .mem_read_i(mem_read_i), .read_data_o(read_data_o),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    txn_t t;
    if (!rst_i && mem_req_o && mem_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn actual addr=%h we=%b required none", mem_addr_o, mem_we_o);
      end else begin
        t = exp_q.pop_front();
        chk("txn_we", 32'(mem_we_o), 32'(t.we));
        chk("txn_addr", mem_addr_o, t.addr);
        if (t.we) chk("txn_wdata", mem_wdata_o, t.data);
        else begin
          chk("load_data", read_data_o, t.data);
          chk("load_stall", 32'(stall_o), 32'd0);
        end
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit expect_write);
    mem_write_i = 1'b1;
    data_addr_i = a;
    write_data_i = d;
    if (expect_write) exp_q.push_back('{1'b1, a, d});
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!mem_req_o) return;
    end
    checks++;
    errors++;
    $display("FAIL %s actual=busy required=idle", name);
  endtask

  initial begin
    rst_i = 1'b1;
    mem_write_i = 1'b0;
    mem_read_i = 1'b0;
    mem_ack_i = 1'b0;
    data_addr_i = '0;
    write_data_i = '0;
    mem_rdata_i = '0;
    @(negedge clk);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_rdata", read_data_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    cyc;
    rst_i = 1'b0;

    // single store, ack one cycle after request
    cyc;
    store(100, 7, 1);
    @(negedge clk);
    chk("st_stall", 32'(stall_o), 0);
    chk("st_req_before", 32'(mem_req_o), 0);
    cyc;
    mem_write_i = 1'b0;
    @(negedge clk);
    chk("st_req_e1", 32'(mem_req_o), 1);
    chk("st_we_e1", 32'(mem_we_o), 1);
    chk("st_addr_e1", mem_addr_o, 100);
    chk("st_wdata_e1", mem_wdata_o, 7);
    cyc;
    mem_ack_i = 1'b1;
    cyc;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("st_req_done", 32'(mem_req_o), 0);
    chk("st_count_done", 32'(dut.u_fifo.count), 0);

    // fill to DEPTH, fifth store stalls until first pop
    for (int i = 0; i < 4; i++) begin
      cyc;
      store(96 + 4 * i, 32'h100 + i, 1);
    end
    cyc;
    store(112, 32'h104, 1);
    mem_ack_i = 1'b1;
    @(negedge clk);
    chk("full_stall", 32'(stall_o), 1);
    chk("full_count", 32'(dut.u_fifo.count), 4);
    cyc;
    @(negedge clk);
    chk("after_pop_stall", 32'(stall_o), 0);
    cyc;
    mem_write_i = 1'b0;
    wait_idle("drain_timeout");
    mem_ack_i = 1'b0;
    chk("drain_count", 32'(dut.u_fifo.count), 0);

    // two stores to one address drain in order
    cyc;
    store(100, 3, 1);
    cyc;
    store(100, 7, 1);
    cyc;
    mem_write_i = 1'b0;
`ifdef STORE_FWD_EN
    mem_read_i = 1'b1;
    data_addr_i = 100;
    @(negedge clk);
    chk("fwd_data", read_data_o, 7);
    chk("fwd_stall", 32'(stall_o), 0);
    cyc;
    mem_read_i = 1'b0;
`endif
    mem_ack_i = 1'b1;
    wait_idle("same_addr_timeout");
    mem_ack_i = 1'b0;

    // load behind a pending store to the same address
    cyc;
    store(96, 32'h55, 1);
    cyc;
    mem_write_i = 1'b0;
    mem_read_i = 1'b1;
    data_addr_i = 96;
`ifdef STORE_FWD_EN
    @(negedge clk);
    chk("fwd96_stall", 32'(stall_o), 0);
    chk("fwd96_data", read_data_o, 32'h55);
    cyc;
    mem_read_i = 1'b0;
    mem_ack_i = 1'b1;
    wait_idle("fwd96_timeout");
    mem_ack_i = 1'b0;
`else
    mem_rdata_i = 32'h1234;
    exp_q.push_back('{1'b0, 96, 32'h1234});
    @(negedge clk);
    chk("ld_wait_stall0", 32'(stall_o), 1);
    cyc;
    @(negedge clk);
    chk("ld_wait_stall1", 32'(stall_o), 1);
    cyc;
    mem_ack_i = 1'b1;
    @(negedge clk);
    chk("ld_drain_stall", 32'(stall_o), 1);
    cyc;
    @(negedge clk);
    chk("ld_idle_stall", 32'(stall_o), 1);
    chk("ld_idle_req", 32'(mem_req_o), 0);
    cyc;
    @(negedge clk);
    chk("ld_ack_stall", 32'(stall_o), 0);
    chk("ld_ack_data", read_data_o, 32'h1234);
    cyc;
    mem_read_i = 1'b0;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("ld_done_req", 32'(mem_req_o), 0);
`endif

    // load from empty buffer, ack after three cycles
    cyc;
    mem_read_i = 1'b1;
    data_addr_i = 200;
    mem_rdata_i = 32'hDEAD;
    exp_q.push_back('{1'b0, 200, 32'hDEAD});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd_stall_wait", 32'(stall_o), 1);
      cyc;
    end
    mem_ack_i = 1'b1;
    @(negedge clk);
    chk("rd_ack_stall", 32'(stall_o), 0);
    chk("rd_ack_data", read_data_o, 32'hDEAD);
    cyc;
    mem_read_i = 1'b0;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("rd_done_req", 32'(mem_req_o), 0);

    // reset during a write abandons it
    cyc;
    store(120, 32'h99, 0);
    cyc;
    mem_write_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_before", 32'(mem_req_o), 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid_req", 32'(mem_req_o), 0);
    chk("rst_mid_count", 32'(dut.u_fifo.count), 0);
    cyc;
    cyc;
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_req", 32'(mem_req_o), 0);
    end
    mem_ack_i = 1'b0;

    cyc;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
